// File: rtl/hms_bcd_converter_pkg.sv
// Shared constants and types for the HMS-to-BCD display converter.
// Field positions follow the packed time word produced by the timing block.
package hms_bcd_converter_pkg;

  localparam int HOURS_MSB = 18;
  localparam int HOURS_LSB = 12;
  localparam int MINS_MSB  = 11;
  localparam int MINS_LSB  = 6;
  localparam int SECS_MSB  = 5;
  localparam int SECS_LSB  = 0;

  localparam int FIELD_W      = 7;
  localparam int DABBLE_STEPS = 7;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

endpackage

// File: rtl/hms_bcd_converter_dabble_step.sv
// One serial double-dabble step: add-3 correction on each BCD nibble, then shift
// the accumulator left, pulling in the MSB of the binary shift register.
module dabble_step
  import hms_bcd_converter_pkg::*;
(
  input  logic [7:0]         acc_i,
  input  logic [FIELD_W-1:0] sr_i,
  input  logic               serial_i,
  output logic [7:0]         acc_o,
  output logic [FIELD_W-1:0] sr_o
);

  logic [3:0] lo_adj;
  logic [3:0] hi_adj;

  always_comb begin
    lo_adj = (acc_i[3:0] >= 4'd5) ? acc_i[3:0] + 4'd3 : acc_i[3:0];
    hi_adj = (acc_i[7:4] >= 4'd5) ? acc_i[7:4] + 4'd3 : acc_i[7:4];
    // The bit shifted out of the tens nibble is a hundreds digit and is dropped.
    acc_o  = ({hi_adj, lo_adj} << 1) | {7'b0, sr_i[FIELD_W-1]};
    sr_o   = {sr_i[FIELD_W-2:0], serial_i};
  end

endmodule

// File: rtl/hms_bcd_converter.sv
// Converts packed binary hh:mm:ss into six BCD digits with a 7-step serial
// double-dabble per field, and toggles the display colon on each half-second.
module hms_bcd_converter #(
  parameter int         HOUR_LIMIT   = 99,
  parameter int         MINSEC_LIMIT = 59,
  parameter logic [3:0] BLANK_CODE   = hms_bcd_converter_pkg::BLANK_CODE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [18:0] HMS_time,
  input  logic        sec_pulse,
  input  logic        half_sec_pulse,
  output logic [23:0] bcd_time,
  output logic        bcd_valid,
  output logic        busy,
  output logic        range_err,
  output logic        colon
);

  import hms_bcd_converter_pkg::*;

  localparam logic [FIELD_W-1:0] HOUR_LIM   = FIELD_W'(HOUR_LIMIT);
  localparam logic [FIELD_W-1:0] MINSEC_LIM = FIELD_W'(MINSEC_LIMIT);
  localparam logic [2:0]         STEP_LAST  = 3'(DABBLE_STEPS - 1);

  state_e state_q, state_d;

  logic [2:0]         step_q, step_d;
  logic [FIELD_W-1:0] hrs_sr_q, hrs_sr_d, hrs_sr_nxt;
  logic [FIELD_W-1:0] min_sr_q, min_sr_d, min_sr_nxt;
  logic [FIELD_W-1:0] sec_sr_q, sec_sr_d, sec_sr_nxt;
  logic [7:0]         hrs_acc_q, hrs_acc_d, hrs_acc_nxt;
  logic [7:0]         min_acc_q, min_acc_d, min_acc_nxt;
  logic [7:0]         sec_acc_q, sec_acc_d, sec_acc_nxt;
  logic [2:0]         err_q, err_d;  // {hours, minutes, seconds}

  logic [23:0] bcd_time_q, bcd_time_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic        range_err_q, range_err_d;
  logic        colon_q, colon_d;

  dabble_step u_dabble_hrs (
    .acc_i    (hrs_acc_q),
    .sr_i     (hrs_sr_q),
    .serial_i (1'b0),
    .acc_o    (hrs_acc_nxt),
    .sr_o     (hrs_sr_nxt)
  );

  dabble_step u_dabble_min (
    .acc_i    (min_acc_q),
    .sr_i     (min_sr_q),
    .serial_i (1'b0),
    .acc_o    (min_acc_nxt),
    .sr_o     (min_sr_nxt)
  );

  dabble_step u_dabble_sec (
    .acc_i    (sec_acc_q),
    .sr_i     (sec_sr_q),
    .serial_i (1'b0),
    .acc_o    (sec_acc_nxt),
    .sr_o     (sec_sr_nxt)
  );

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (sec_pulse) state_d = SHIFT;
      SHIFT:   if (step_q == STEP_LAST) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: snapshot on accept, then one dabble step per SHIFT cycle.
  always_comb begin
    step_d    = step_q;
    hrs_sr_d  = hrs_sr_q;
    min_sr_d  = min_sr_q;
    sec_sr_d  = sec_sr_q;
    hrs_acc_d = hrs_acc_q;
    min_acc_d = min_acc_q;
    sec_acc_d = sec_acc_q;
    err_d     = err_q;
    if (state_q == IDLE && sec_pulse) begin
      hrs_sr_d  = HMS_time[HOURS_MSB:HOURS_LSB];
      min_sr_d  = {1'b0, HMS_time[MINS_MSB:MINS_LSB]};
      sec_sr_d  = {1'b0, HMS_time[SECS_MSB:SECS_LSB]};
      hrs_acc_d = 8'h00;
      min_acc_d = 8'h00;
      sec_acc_d = 8'h00;
      step_d    = 3'd0;
      err_d     = {HMS_time[HOURS_MSB:HOURS_LSB] > HOUR_LIM,
                   {1'b0, HMS_time[MINS_MSB:MINS_LSB]} > MINSEC_LIM,
                   {1'b0, HMS_time[SECS_MSB:SECS_LSB]} > MINSEC_LIM};
    end else if (state_q == SHIFT) begin
      hrs_sr_d  = hrs_sr_nxt;
      min_sr_d  = min_sr_nxt;
      sec_sr_d  = sec_sr_nxt;
      hrs_acc_d = hrs_acc_nxt;
      min_acc_d = min_acc_nxt;
      sec_acc_d = sec_acc_nxt;
      step_d    = step_q + 3'd1;
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    bcd_valid_d = (state_q == COMMIT);
    bcd_time_d  = bcd_time_q;
    range_err_d = range_err_q;
    colon_d     = colon_q ^ half_sec_pulse;
    if (state_q == COMMIT) begin
      bcd_time_d  = {err_q[2] ? {2{BLANK_CODE}} : hrs_acc_q,
                     err_q[1] ? {2{BLANK_CODE}} : min_acc_q,
                     err_q[0] ? {2{BLANK_CODE}} : sec_acc_q};
      range_err_d = |err_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_q      <= 3'd0;
      hrs_sr_q    <= '0;
      min_sr_q    <= '0;
      sec_sr_q    <= '0;
      hrs_acc_q   <= 8'h00;
      min_acc_q   <= 8'h00;
      sec_acc_q   <= 8'h00;
      err_q       <= 3'b000;
      bcd_time_q  <= 24'h000000;
      bcd_valid_q <= 1'b0;
      range_err_q <= 1'b0;
      colon_q     <= 1'b0;
    end else begin
      step_q      <= step_d;
      hrs_sr_q    <= hrs_sr_d;
      min_sr_q    <= min_sr_d;
      sec_sr_q    <= sec_sr_d;
      hrs_acc_q   <= hrs_acc_d;
      min_acc_q   <= min_acc_d;
      sec_acc_q   <= sec_acc_d;
      err_q       <= err_d;
      bcd_time_q  <= bcd_time_d;
      bcd_valid_q <= bcd_valid_d;
      range_err_q <= range_err_d;
      colon_q     <= colon_d;
    end
  end

  assign bcd_time  = bcd_time_q;
  assign bcd_valid = bcd_valid_q;
  assign range_err = range_err_q;
  assign colon     = colon_q;

endmodule

// File: tb/tb_hms_bcd_converter.sv
// Directed bench for hms_bcd_converter: expected digits are queued on each
// accepted sec_pulse and checked when bcd_valid appears.
`timescale 1ns/1ps
module tb_hms_bcd_converter;

  typedef struct packed {
    logic [23:0] bcd;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [18:0] HMS_time = '0;
  logic        sec_pulse = 1'b0;
  logic        half_sec_pulse = 1'b0;
  logic [23:0] bcd_time;
  logic        bcd_valid;
  logic        busy;
  logic        range_err;
  logic        colon;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  hms_bcd_converter dut (
    .clock          (clock),
    .reset          (reset),
    .HMS_time       (HMS_time),
    .sec_pulse      (sec_pulse),
    .half_sec_pulse (half_sec_pulse),
    .bcd_time       (bcd_time),
    .bcd_valid      (bcd_valid),
    .busy           (busy),
    .range_err      (range_err),
    .colon          (colon)
  );

  always #1000 clock = ~clock;  // 500 kHz

  initial begin
    #40_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] hms(input int h, input int m, input int s);
    return {7'(h), 6'(m), 6'(s)};
  endfunction

  // Scoreboard consumer.
  always @(negedge clock) begin
    if (!reset && bcd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid_queue_size", sb_q.size(), 1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("bcd_time", bcd_time, e.bcd);
        check("range_err", range_err, e.err);
      end
    end
  end

  // One conversion: drive at a negedge so E0 is the following posedge.
  task automatic run_conv(input logic [18:0] t, input logic [23:0] exp_bcd, input logic exp_err,
                          input logic with_half, input logic exp_colon);
    int lat;
    int busy_cnt;
    lat = -1;
    busy_cnt = 0;
    @(negedge clock);
    HMS_time = t;
    sec_pulse = 1'b1;
    half_sec_pulse = with_half;
    sb_q.push_back('{bcd: exp_bcd, err: exp_err});
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i == 1) begin
        sec_pulse = 1'b0;
        half_sec_pulse = 1'b0;
        if (with_half) check("colon_with_sec_pulse", colon, exp_colon);
      end
      if (busy) busy_cnt++;
      if (bcd_valid) begin
        lat = i - 1;
        break;
      end
    end
    check("latency", lat, 8);
    check("busy_cycles", busy_cnt, 8);
    @(negedge clock);
    check("valid_one_cycle", bcd_valid, 1'b0);
    check("bcd_time_hold", bcd_time, exp_bcd);
  endtask

  task automatic half_strobe(input logic exp_colon);
    @(negedge clock);
    half_sec_pulse = 1'b1;
    @(negedge clock);
    half_sec_pulse = 1'b0;
    check("colon", colon, exp_colon);
  endtask

  initial begin
    int valids;

    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_bcd_time", bcd_time, 24'h000000);
    check("reset_bcd_valid", bcd_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_range_err", range_err, 1'b0);
    check("reset_colon", colon, 1'b0);

    run_conv(hms(12, 34, 56), 24'h123456, 1'b0, 1'b0, 1'b0);
    run_conv(hms(99, 59, 59), 24'h995959, 1'b0, 1'b0, 1'b0);
    run_conv(hms(0, 0, 0),    24'h000000, 1'b0, 1'b0, 1'b0);
    run_conv(hms(100, 60, 5), 24'hFFFF05, 1'b1, 1'b0, 1'b0);
    run_conv(hms(7, 0, 61),   24'h0700FF, 1'b1, 1'b0, 1'b0);

    // sec_pulse re-asserted at E3 must be ignored.
    @(negedge clock);
    HMS_time = hms(1, 2, 3);
    sec_pulse = 1'b1;
    sb_q.push_back('{bcd: 24'h010203, err: 1'b0});
    valids = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      sec_pulse = (i == 3);
      if (i == 3) HMS_time = hms(4, 5, 6);
      if (bcd_valid) valids++;
    end
    check("restart_valid_count", valids, 1);
    check("restart_bcd_time", bcd_time, 24'h010203);

    // Reset in the middle of a conversion.
    @(negedge clock);
    HMS_time = hms(7, 8, 9);
    sec_pulse = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      sec_pulse = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("midreset_bcd_time", bcd_time, 24'h000000);
    check("midreset_busy", busy, 1'b0);
    check("midreset_valid", bcd_valid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    valids = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      if (bcd_valid) valids++;
    end
    check("midreset_no_valid", valids, 0);
    check("midreset_idle", busy, 1'b0);
    run_conv(hms(21, 43, 7), 24'h214307, 1'b0, 1'b0, 1'b0);

    // Colon toggles, one strobe coinciding with a sec_pulse.
    half_strobe(1'b1);
    run_conv(hms(23, 59, 58), 24'h235958, 1'b0, 1'b1, 1'b0);
    half_strobe(1'b1);
    half_strobe(1'b0);

    repeat (3) @(negedge clock);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
